// File: rtl/pa_ifu_ibuf_ring_pkg.sv
// pa_ifu_ibuf_ring_pkg -- shared IFU instruction-buffer definitions.
//   Halfword entry width, pred-taken width, the fixed part of the entry
//   packing and the halt-info width default (`TDT_HINFO_WIDTH).
//   Stored entry layout, MSB first: {halt_info, acc_err, pred_taken, inst}.
`ifndef TDT_HINFO_WIDTH
`define TDT_HINFO_WIDTH 15
`endif

package pa_ifu_ibuf_ring_pkg;

  localparam int unsigned IFU_HW_W    = 16;
  localparam int unsigned IFU_PRED_W  = 2;
  localparam int unsigned IFU_HINFO_W = `TDT_HINFO_WIDTH;

  // Fixed-width low part of an entry; halt_info sits above it.
  typedef struct packed {
    logic                  acc_err;
    logic [IFU_PRED_W-1:0] pred_taken;
    logic [IFU_HW_W-1:0]   inst;
  } ibuf_base_t;

  localparam int unsigned IBUF_BASE_W = $bits(ibuf_base_t);

  // Halfword counts of 3 are not legal requests and behave as 0.
  function automatic logic [1:0] ibuf_num_norm(input logic [1:0] num);
    return (num == 2'd3) ? 2'd0 : num;
  endfunction

endpackage

// File: rtl/pa_ifu_ibuf_ring_entry.sv
// pa_ifu_ibuf_ring_entry -- one instruction-buffer entry's data register.
//   clk_i      : clock
//   we0_i      : write from create slot 0
//   wdata0_i   : slot 0 packed entry
//   we1_i      : write from create slot 1
//   wdata1_i   : slot 1 packed entry
//   data_o     : stored packed entry
// The data register has no reset; it is only meaningful while counted valid.
module pa_ifu_ibuf_ring_entry
  import pa_ifu_ibuf_ring_pkg::*;
#(
  parameter int unsigned W = IBUF_BASE_W + IFU_HINFO_W
) (
  input  logic         clk_i,
  input  logic         we0_i,
  input  logic [W-1:0] wdata0_i,
  input  logic         we1_i,
  input  logic [W-1:0] wdata1_i,
  output logic [W-1:0] data_o
);

  logic         we;
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    we     = we0_i | we1_i;
    data_d = we0_i ? wdata0_i : wdata1_i;
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/pa_ifu_ibuf_ring.sv
// pa_ifu_ibuf_ring -- circular IFU instruction buffer of 16-bit halfwords.
//   Up to two halfwords created and up to two consumed per cycle; the two
//   oldest entries are presented on head0/head1.
// Ports:
//   forever_cpuclk, cpurst_b (async, active low)
//   ibuf_flush_en              : discard all entries (next cycle)
//   ibuf_create_num            : halfwords offered (0/1/2, 3 = 0)
//   ibuf_create_*0/1           : slot-0 / slot-1 entry fields
//   ibuf_create_rdy            : at least two free entries
//   ibuf_pop_num               : halfwords consumed (0/1/2, 3 = 0)
//   ibuf_head0/1_*             : oldest / second-oldest entry and valids
//   ibuf_entry_cnt, ibuf_empty, ibuf_full
// Optional feature: define PA_IFU_IBUF_BYPASS_EN to let an empty buffer
// present same-cycle create slots directly on the heads.
module pa_ifu_ibuf_ring
  import pa_ifu_ibuf_ring_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HINFO_W = IFU_HINFO_W
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      ibuf_flush_en,
  input  logic [1:0]                ibuf_create_num,
  input  logic [15:0]               ibuf_create_inst0,
  input  logic [15:0]               ibuf_create_inst1,
  input  logic [1:0]                ibuf_create_pred_taken0,
  input  logic [1:0]                ibuf_create_pred_taken1,
  input  logic [HINFO_W-1:0]        ibuf_create_halt_info0,
  input  logic [HINFO_W-1:0]        ibuf_create_halt_info1,
  input  logic                      ibuf_create_acc_err0,
  input  logic                      ibuf_create_acc_err1,
  output logic                      ibuf_create_rdy,
  input  logic [1:0]                ibuf_pop_num,
  output logic                      ibuf_head0_vld,
  output logic [15:0]               ibuf_head0_inst,
  output logic [1:0]                ibuf_head0_pred_taken,
  output logic [HINFO_W-1:0]        ibuf_head0_halt_info,
  output logic                      ibuf_head0_acc_err,
  output logic                      ibuf_head1_vld,
  output logic [15:0]               ibuf_head1_inst,
  output logic [1:0]                ibuf_head1_pred_taken,
  output logic [HINFO_W-1:0]        ibuf_head1_halt_info,
  output logic                      ibuf_head1_acc_err,
  output logic [$clog2(DEPTH):0]    ibuf_entry_cnt,
  output logic                      ibuf_empty,
  output logic                      ibuf_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = IBUF_BASE_W + HINFO_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       create_num, pop_num, acc_num, pop_clamp;
  logic [CNT_W-1:0] free_cnt, avail_cnt;
  logic             create_ok, byp_en, slot0_we, slot1_we;
  logic [PTR_W-1:0] wptr_p1, rptr_p1;

  logic [ENT_W-1:0] slot0_data, slot1_data;
  logic [ENT_W-1:0] ent_q [DEPTH];
  logic [ENT_W-1:0] h0_ent, h1_ent;
  ibuf_base_t       h0_base, h1_base;

  always_comb begin
    slot0_data = {ibuf_create_halt_info0, ibuf_create_acc_err0,
                  ibuf_create_pred_taken0, ibuf_create_inst0};
    slot1_data = {ibuf_create_halt_info1, ibuf_create_acc_err1,
                  ibuf_create_pred_taken1, ibuf_create_inst1};
  end

  always_comb begin
    create_num = ibuf_num_norm(ibuf_create_num);
    pop_num    = ibuf_num_norm(ibuf_pop_num);
    free_cnt   = DEPTH_C - cnt_q;
    // Acceptance is judged on the pre-pop count: a create is all-or-nothing.
    create_ok  = CNT_W'(create_num) <= free_cnt;
    acc_num    = create_ok ? create_num : 2'd0;
`ifdef PA_IFU_IBUF_BYPASS_EN
    byp_en     = (cnt_q == '0) && !ibuf_flush_en;
`else
    byp_en     = 1'b0;
`endif
    // While bypassing, the poppable entries are this cycle's accepted creates.
    avail_cnt  = byp_en ? CNT_W'(acc_num) : cnt_q;
    pop_clamp  = (CNT_W'(pop_num) > avail_cnt) ? avail_cnt[1:0] : pop_num;
    // Bypassed entries consumed in the same cycle are never written; both
    // pointers still advance past them so the ring stays aligned.
    slot0_we   = !ibuf_flush_en && (acc_num != 2'd0) && !(byp_en && (pop_clamp != 2'd0));
    slot1_we   = !ibuf_flush_en && (acc_num == 2'd2) && !(byp_en && (pop_clamp == 2'd2));
    wptr_p1    = wptr_q + PTR_W'(1);
    rptr_p1    = rptr_q + PTR_W'(1);
  end

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (ibuf_flush_en) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      cnt_d  = cnt_q + CNT_W'(acc_num) - CNT_W'(pop_clamp);
      wptr_d = wptr_q + PTR_W'(acc_num);
      rptr_d = rptr_q + PTR_W'(pop_clamp);
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    pa_ifu_ibuf_ring_entry #(
      .W (ENT_W)
    ) u_ent (
      .clk_i    (forever_cpuclk),
      .we0_i    (slot0_we && (wptr_q  == PTR_W'(gi))),
      .wdata0_i (slot0_data),
      .we1_i    (slot1_we && (wptr_p1 == PTR_W'(gi))),
      .wdata1_i (slot1_data),
      .data_o   (ent_q[gi])
    );
  end

  always_comb begin
    if (byp_en) begin
      h0_ent         = slot0_data;
      h1_ent         = slot1_data;
      ibuf_head0_vld = acc_num != 2'd0;
      ibuf_head1_vld = acc_num == 2'd2;
    end else begin
      h0_ent         = ent_q[rptr_q];
      h1_ent         = ent_q[rptr_p1];
      ibuf_head0_vld = cnt_q > CNT_W'(0);
      ibuf_head1_vld = cnt_q > CNT_W'(1);
    end
    h0_base = ibuf_base_t'(h0_ent[IBUF_BASE_W-1:0]);
    h1_base = ibuf_base_t'(h1_ent[IBUF_BASE_W-1:0]);

    ibuf_head0_inst       = h0_base.inst;
    ibuf_head0_pred_taken = h0_base.pred_taken;
    ibuf_head0_acc_err    = h0_base.acc_err;
    ibuf_head0_halt_info  = h0_ent[ENT_W-1:IBUF_BASE_W];
    ibuf_head1_inst       = h1_base.inst;
    ibuf_head1_pred_taken = h1_base.pred_taken;
    ibuf_head1_acc_err    = h1_base.acc_err;
    ibuf_head1_halt_info  = h1_ent[ENT_W-1:IBUF_BASE_W];
  end

  always_comb begin
    ibuf_entry_cnt  = cnt_q;
    ibuf_empty      = cnt_q == '0;
    ibuf_full       = cnt_q == DEPTH_C;
    ibuf_create_rdy = cnt_q <= (DEPTH_C - CNT_W'(2));
  end

endmodule

// File: tb/tb_pa_ifu_ibuf_ring.sv
module tb_pa_ifu_ibuf_ring;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HW    = 15;
`ifdef PA_IFU_IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0]   inst;
    logic [1:0]    pred;
    logic [HW-1:0] hinfo;
    logic          acc;
  } ent_t;

  typedef struct {
    logic [1:0] cn;
    logic [1:0] pn;
    logic       fl;
    int         exp_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    cnum = '0, pnum = '0;
  logic [15:0]   inst0 = '0, inst1 = '0;
  logic [1:0]    pred0 = '0, pred1 = '0;
  logic [HW-1:0] hi0 = '0, hi1 = '0;
  logic          ae0 = 1'b0, ae1 = 1'b0;
  logic          rdy, h0v, h1v, h0ae, h1ae, empty, full;
  logic [15:0]   h0i, h1i;
  logic [1:0]    h0p, h1p;
  logic [HW-1:0] h0h, h1h;
  logic [3:0]    cnt;

  ent_t        sb[$];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] tag = 16'h1111;

  always #5 clk = ~clk;

  pa_ifu_ibuf_ring #(
    .DEPTH   (DEPTH),
    .HINFO_W (HW)
  ) dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_n),
    .ibuf_flush_en           (flush),
    .ibuf_create_num         (cnum),
    .ibuf_create_inst0       (inst0),
    .ibuf_create_inst1       (inst1),
    .ibuf_create_pred_taken0 (pred0),
    .ibuf_create_pred_taken1 (pred1),
    .ibuf_create_halt_info0  (hi0),
    .ibuf_create_halt_info1  (hi1),
    .ibuf_create_acc_err0    (ae0),
    .ibuf_create_acc_err1    (ae1),
    .ibuf_create_rdy         (rdy),
    .ibuf_pop_num            (pnum),
    .ibuf_head0_vld          (h0v),
    .ibuf_head0_inst         (h0i),
    .ibuf_head0_pred_taken   (h0p),
    .ibuf_head0_halt_info    (h0h),
    .ibuf_head0_acc_err      (h0ae),
    .ibuf_head1_vld          (h1v),
    .ibuf_head1_inst         (h1i),
    .ibuf_head1_pred_taken   (h1p),
    .ibuf_head1_halt_info    (h1h),
    .ibuf_head1_acc_err      (h1ae),
    .ibuf_entry_cnt          (cnt),
    .ibuf_empty              (empty),
    .ibuf_full               (full)
  );

  // Side fields derived from the instruction so every field is distinguishable.
  function automatic ent_t mk(input logic [15:0] i);
    ent_t e;
    e.inst  = i;
    e.pred  = i[1:0] ^ i[9:8];
    e.hinfo = {i[6:0], i[15:8]};
    e.acc   = ^i;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input int exp_cnt);
    chk({nm, ".cnt"},   64'(cnt),   64'(exp_cnt));
    chk({nm, ".empty"}, 64'(empty), 64'(exp_cnt == 0));
    chk({nm, ".full"},  64'(full),  64'(exp_cnt == int'(DEPTH)));
    chk({nm, ".rdy"},   64'(rdy),   64'(exp_cnt <= int'(DEPTH) - 2));
  endtask

  // One cycle: drive, check heads mid-cycle against the scoreboard, then
  // check the count after the edge against the hand-computed value.
  task automatic step(input logic [1:0] cn, input logic [1:0] pn, input logic fl,
                      input int exp_cnt, input string nm);
    int   pre, cne, pne, acc, avail, npop;
    bit   byp;
    ent_t e0, e1;
    pre = sb.size();
    cne = (cn == 2'd3) ? 0 : int'(cn);
    pne = (pn == 2'd3) ? 0 : int'(pn);
    acc = (cne <= int'(DEPTH) - pre) ? cne : 0;
    e0  = mk(tag);
    e1  = mk(tag + 16'h1111);
    if (acc == 1) tag = tag + 16'h1111;
    if (acc == 2) tag = tag + 16'h2222;
    cnum = cn; pnum = pn; flush = fl;
    inst0 = e0.inst; pred0 = e0.pred; hi0 = e0.hinfo; ae0 = e0.acc;
    inst1 = e1.inst; pred1 = e1.pred; hi1 = e1.hinfo; ae1 = e1.acc;
    byp = BYP && (pre == 0) && !fl;
    if (byp) begin
      if (acc >= 1) sb.push_back(e0);
      if (acc == 2) sb.push_back(e1);
    end
    avail = sb.size();
    npop  = (pne < avail) ? pne : avail;
    @(negedge clk);
    chk({nm, ".h0v"}, 64'(h0v), 64'(avail > 0));
    chk({nm, ".h1v"}, 64'(h1v), 64'(avail > 1));
    if (avail > 0) chk({nm, ".head0"}, 64'({h0i, h0p, h0h, h0ae}), 64'(sb[0]));
    if (avail > 1) chk({nm, ".head1"}, 64'({h1i, h1p, h1h, h1ae}), 64'(sb[1]));
    if (fl) begin
      sb.delete();
    end else begin
      repeat (npop) void'(sb.pop_front());
      if (!byp) begin
        if (acc >= 1) sb.push_back(e0);
        if (acc == 2) sb.push_back(e1);
      end
    end
    @(posedge clk);
    #1;
    cnum = '0; pnum = '0; flush = 1'b0;
    chk_state(nm, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values while held in reset.
    #12;
    chk_state("reset", 0);
    chk("reset.h0v", 64'(h0v), 64'(0));
    chk("reset.h1v", 64'(h1v), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First create of two halfwords.
    step(2'd2, 2'd0, 1'b0, 2, "first");
    chk("first.h0inst", 64'(h0i), 64'(16'h1111));
    chk("first.h1inst", 64'(h1i), 64'(16'h2222));

    // {create, pop, flush, expected count after the cycle}
    vecs.push_back('{2'd2, 2'd0, 1'b0, 4});
    vecs.push_back('{2'd2, 2'd1, 1'b0, 5});
    vecs.push_back('{2'd2, 2'd1, 1'b0, 6});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 8}); // full
    vecs.push_back('{2'd1, 2'd2, 1'b0, 6}); // create dropped at full, pop wins
    vecs.push_back('{2'd3, 2'd0, 1'b0, 6}); // create 3 behaves as 0
    vecs.push_back('{2'd2, 2'd3, 1'b0, 8}); // pop 3 behaves as 0
    vecs.push_back('{2'd0, 2'd2, 1'b0, 6});
    vecs.push_back('{2'd2, 2'd2, 1'b0, 6}); // exactly two free
    vecs.push_back('{2'd0, 2'd2, 1'b0, 4});
    vecs.push_back('{2'd0, 2'd1, 1'b0, 3});
    vecs.push_back('{2'd2, 2'd1, 1'b1, 0}); // flush overrides create/pop
    vecs.push_back('{2'd1, 2'd0, 1'b0, 1});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 0}); // pop clamped to 1
    vecs.push_back('{2'd0, 2'd0, 1'b0, 0});
    // Wrap-around: write 7, pop 6, write 6, drain.
    vecs.push_back('{2'd2, 2'd0, 1'b0, 2});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 4});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 6});
    vecs.push_back('{2'd1, 2'd0, 1'b0, 7});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 5});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 3});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 1});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 3});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 5});
    vecs.push_back('{2'd2, 2'd0, 1'b0, 7});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 5});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 3});
    vecs.push_back('{2'd0, 2'd2, 1'b0, 1});
    vecs.push_back('{2'd0, 2'd1, 1'b0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cn, vecs[i].pn, vecs[i].fl, vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // Create-and-pop of one halfword on an empty buffer.
    tag = 16'hABCD;
    if (BYP) begin
      step(2'd1, 2'd1, 1'b0, 0, "byp");
    end else begin
      step(2'd1, 2'd1, 1'b0, 1, "nobyp");
      chk("nobyp.h0inst", 64'(h0i), 64'(16'hABCD));
      step(2'd0, 2'd1, 1'b0, 0, "nobyp.pop");
    end

    // Reset taken mid-operation with five entries stored.
    step(2'd2, 2'd0, 1'b0, 2, "pre_rst0");
    step(2'd2, 2'd0, 1'b0, 4, "pre_rst1");
    step(2'd1, 2'd0, 1'b0, 5, "pre_rst2");
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("midrst", 0);
    chk("midrst.h0v", 64'(h0v), 64'(0));
    chk("midrst.h1v", 64'(h1v), 64'(0));
    sb.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2'd2, 2'd0, 1'b0, 2, "post_rst0");
    step(2'd0, 2'd2, 1'b0, 0, "post_rst1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pa_ifu_ibuf_ring.md
PA_IFU_IBUF_RING -- requirements
Module: pa_ifu_ibuf_ring

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 16-bit halfword entries; power of two, at least 4.
REQ-002 SHALL have parameter HINFO_W, default `TDT_HINFO_WIDTH (15), per-entry halt-info width.
REQ-003 SHALL have port forever_cpuclk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port cpurst_b, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ibuf_flush_en, input, 1, discard all entries.
REQ-006 SHALL have port ibuf_create_num, input, 2, halfwords offered this cycle (0/1/2; 3 treated as 0).
REQ-007 SHALL have ports ibuf_create_inst0/1 (16), ibuf_create_pred_taken0/1 (2), ibuf_create_halt_info0/1 (HINFO_W), ibuf_create_acc_err0/1 (1), inputs, slot-0 then slot-1 entry data.
REQ-008 SHALL have port ibuf_create_rdy, output, 1, high when free entries >= 2.
REQ-009 SHALL have port ibuf_pop_num, input, 2, halfwords consumed this cycle (0/1/2; 3 treated as 0).
REQ-010 SHALL have ports ibuf_head0/1_vld (1), ibuf_head0/1_inst (16), ibuf_head0/1_pred_taken (2), ibuf_head0/1_halt_info (HINFO_W), ibuf_head0/1_acc_err (1), outputs, oldest and second-oldest entry.
REQ-011 SHALL have port ibuf_entry_cnt, output, log2(DEPTH)+1, stored entries.
REQ-012 SHALL have ports ibuf_empty and ibuf_full, outputs, 1, cnt==0 and cnt==DEPTH.

Function
REQ-013 SHALL store entries in a circular array with write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH) and count register.
REQ-014 SHALL accept a create atomically only when create_num <= DEPTH-cnt (pre-pop value); otherwise the whole create is dropped, no partial write.
REQ-015 SHALL write slot 0 at wptr and slot 1 at wptr+1 (mod DEPTH); wptr advances by the accepted number.
REQ-016 SHALL clamp pop_num to the number of valid head entries; rptr advances by the clamped number.
REQ-017 SHALL update cnt next cycle as cnt + accepted_create - clamped_pop; create and pop in the same cycle both take effect.
REQ-018 SHALL drive head0 from entry rptr and head1 from rptr+1; headN_vld = cnt > N; data of invalid heads is don't-care.
REQ-019 SHALL give one-cycle create-to-head latency when not bypassing.
REQ-020 SHALL, on ibuf_flush_en, next cycle set cnt, wptr, rptr to 0, ignoring same-cycle create and pop; data array is not cleared.
REQ-021 SHALL gate data-array writes per entry by write enable only; data registers carry no reset.

Reset
REQ-022 SHALL on cpurst_b low asynchronously clear cnt, wptr, rptr; outputs: ibuf_empty=1, ibuf_full=0, ibuf_create_rdy=1, head0/1_vld=0, ibuf_entry_cnt=0.
REQ-023 SHALL take reset mid-operation at once, losing all stored entries; first cycle after release behaves as empty.

Configuration
REQ-024 SHALL support macro PA_IFU_IBUF_BYPASS_EN.
REQ-025 With PA_IFU_IBUF_BYPASS_EN, when cnt==0 and ibuf_flush_en low, heads SHALL show same-cycle create slots (head0=slot0, head1=slot1 when create_num==2); popped bypass entries are not written and wptr/rptr advance equally.
REQ-026 Without PA_IFU_IBUF_BYPASS_EN, heads SHALL show stored entries only (REQ-019 latency always).

Structure
REQ-027 SHALL place halfword entry width (16), pred-taken width (2) and the entry field packing in shared IFU package/define file alongside `TDT_HINFO_WIDTH.
REQ-028 SHALL use one sub-module, pa_ifu_ibuf_ring_entry, holding one entry's data registers with write enable and write-data mux.

Verification
REQ-029 Reset then create_num=2 (inst 0x1111, 0x2222), pop 0 -> next cycle cnt=2, head0_inst=0x1111, head1_inst=0x2222, both vld.
REQ-030 DEPTH=8: fill 8 entries -> full=1, create_rdy=0; create_num=1 with pop_num=2 same cycle -> create dropped, cnt=6.
REQ-031 Write 7, pop 6, write 6 more -> wrap-around; pop order exactly matches write order across index 7->0.
REQ-032 cnt=3, flush_en with create_num=2 and pop_num=1 -> next cycle cnt=0, empty=1, head0_vld=0.
REQ-033 cnt=1, pop_num=2 -> clamped, cnt=0; with BYPASS: cnt=0, create_num=1 inst 0xABCD, pop_num=1 -> head0_inst=0xABCD same cycle, cnt stays 0.
REQ-034 Assert cpurst_b low while cnt=5 -> outputs at reset values immediately; subsequent create behaves as from empty.
